// File: rtl/simple_logic_pkg.sv
// Shared definitions for the simple-logic stage and its result accumulator:
// sample width, accumulator state encoding and a compile-time clog2.
package simple_logic_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/simple_logic_result_accumulator_window_counter.sv
// Sample counter for one accumulation window: clears, counts accepted samples
// and flags the last slot so the window wraps back to zero on its final sample.
module window_counter
  import simple_logic_pkg::*;
#(
  parameter int WINDOW = 4,
  parameter int CNT_W  = clog2(WINDOW)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last = (cnt_q == CNT_W'(WINDOW - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/simple_logic_result_accumulator.sv
// Collects WINDOW unsigned samples over valid/ready and holds their sum and
// truncated average until accepted. Define PEAK_TRACK_EN to add out_peak.
module simple_logic_result_accumulator
  import simple_logic_pkg::*;
#(
  parameter int DATA_W = simple_logic_pkg::DATA_W,
  parameter int WINDOW = 4,
  parameter int CNT_W  = clog2(WINDOW),
  parameter int SUM_W  = DATA_W + CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
`ifdef PEAK_TRACK_EN
  output logic [DATA_W-1:0] out_peak,
`endif
  output logic [DATA_W-1:0] out_avg
);

  // Average is a plain truncating divide by the power-of-two window.
  function automatic logic [DATA_W-1:0] avg_trunc(input logic [SUM_W-1:0] s);
    return DATA_W'(s >> CNT_W);
  endfunction

`ifdef PEAK_TRACK_EN
  // Strict compare so ties keep the value already held.
  function automatic logic [DATA_W-1:0] peak_keep(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] cand);
    return (cand > cur) ? cand : cur;
  endfunction
`endif

  state_t            state_q, state_d;
  logic [SUM_W-1:0]  sum_p0_q, sum_p0_d;
  logic              vld_p1_q, vld_p1_d;
  logic [SUM_W-1:0]  out_sum_p1_q, out_sum_p1_d;
  logic [DATA_W-1:0] out_avg_p1_q, out_avg_p1_d;
`ifdef PEAK_TRACK_EN
  logic [DATA_W-1:0] peak_p0_q, peak_p0_d;
  logic [DATA_W-1:0] out_peak_p1_q, out_peak_p1_d;
`endif

  logic              accept;
  logic              take;
  logic              cnt_clear;
  logic              cnt_last;
  logic [CNT_W-1:0]  cnt;
  logic [SUM_W-1:0]  in_ext;
  logic [SUM_W-1:0]  sum_next;

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign take      = accept && !flush;
  assign cnt_clear = flush && (state_q != HOLD);
  assign in_ext    = SUM_W'(in_data);
  assign sum_next  = sum_p0_q + in_ext;

  window_counter #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) u_window_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (take),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  // Stage p0: running window accumulation.
  always_comb begin
    state_d      = state_q;
    sum_p0_d     = sum_p0_q;
    vld_p1_d     = vld_p1_q;
    out_sum_p1_d = out_sum_p1_q;
    out_avg_p1_d = out_avg_p1_q;
`ifdef PEAK_TRACK_EN
    peak_p0_d     = peak_p0_q;
    out_peak_p1_d = out_peak_p1_q;
`endif
    case (state_q)
      IDLE: begin
        sum_p0_d = '0;
`ifdef PEAK_TRACK_EN
        peak_p0_d = '0;
`endif
        if (take) begin
          state_d  = ACCUM;
          sum_p0_d = in_ext;
`ifdef PEAK_TRACK_EN
          peak_p0_d = in_data;
`endif
        end
      end
      ACCUM: begin
        if (flush) begin
          state_d  = IDLE;
          sum_p0_d = '0;
`ifdef PEAK_TRACK_EN
          peak_p0_d = '0;
`endif
        end else if (take) begin
          if (cnt_last) begin
            // Stage p1: completed window result, held until downstream accepts.
            state_d      = HOLD;
            sum_p0_d     = '0;
            vld_p1_d     = 1'b1;
            out_sum_p1_d = sum_next;
            out_avg_p1_d = avg_trunc(sum_next);
`ifdef PEAK_TRACK_EN
            peak_p0_d     = '0;
            out_peak_p1_d = peak_keep(peak_p0_q, in_data);
`endif
          end else begin
            sum_p0_d = sum_next;
`ifdef PEAK_TRACK_EN
            peak_p0_d = peak_keep(peak_p0_q, in_data);
`endif
          end
        end
      end
      HOLD: begin
        if (vld_p1_q && out_ready) begin
          state_d  = IDLE;
          vld_p1_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        sum_p0_d = '0;
        vld_p1_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sum_p0_q     <= '0;
      vld_p1_q     <= 1'b0;
      out_sum_p1_q <= '0;
      out_avg_p1_q <= '0;
`ifdef PEAK_TRACK_EN
      peak_p0_q     <= '0;
      out_peak_p1_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sum_p0_q     <= sum_p0_d;
      vld_p1_q     <= vld_p1_d;
      out_sum_p1_q <= out_sum_p1_d;
      out_avg_p1_q <= out_avg_p1_d;
`ifdef PEAK_TRACK_EN
      peak_p0_q     <= peak_p0_d;
      out_peak_p1_q <= out_peak_p1_d;
`endif
    end
  end

  assign out_valid = vld_p1_q;
  assign out_sum   = out_sum_p1_q;
  assign out_avg   = out_avg_p1_q;
`ifdef PEAK_TRACK_EN
  assign out_peak  = out_peak_p1_q;
`endif

endmodule

// File: tb/tb_simple_logic_result_accumulator.sv
// Directed plus randomized bench for simple_logic_result_accumulator against
// a window-list reference model (out_peak checked when PEAK_TRACK_EN is set).
module tb_simple_logic_result_accumulator;

  localparam int DATA_W = 8;
  localparam int WINDOW = 4;
  localparam int SUM_W  = 10;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_avg;
`ifdef PEAK_TRACK_EN
  logic [DATA_W-1:0] out_peak;
`endif

  int checks;
  int errors;

  int win[$];
  bit holding;
  int exp_sum;
  int exp_avg;
  int exp_peak;

  simple_logic_result_accumulator #(
    .DATA_W (DATA_W),
    .WINDOW (WINDOW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef PEAK_TRACK_EN
    .out_peak  (out_peak),
`endif
    .out_avg   (out_avg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: the window is a list of accepted samples; a full list
  // becomes a held result that only a downstream accept releases.
  task automatic model_edge(input bit v, input int d, input bit f, input bit r);
    if (holding) begin
      if (r) holding = 1'b0;
    end else if (f) begin
      win.delete();
    end else if (v) begin
      win.push_back(d);
      if (win.size() == WINDOW) begin
        exp_sum  = 0;
        exp_peak = 0;
        foreach (win[k]) begin
          exp_sum += win[k];
          if (win[k] > exp_peak) exp_peak = win[k];
        end
        exp_avg = exp_sum / WINDOW;
        holding = 1'b1;
        win.delete();
      end
    end
  endtask

  task automatic model_reset();
    win.delete();
    holding = 1'b0;
  endtask

  task automatic compare(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(!holding));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(holding));
    if (holding) begin
      check({tag, ".out_sum"}, 32'(out_sum), 32'(exp_sum));
      check({tag, ".out_avg"}, 32'(out_avg), 32'(exp_avg));
`ifdef PEAK_TRACK_EN
      check({tag, ".out_peak"}, 32'(out_peak), 32'(exp_peak));
`endif
    end
  endtask

  task automatic cycle(input string tag, input bit v, input int d, input bit f, input bit r);
    in_valid  = v;
    in_data   = d[DATA_W-1:0];
    flush     = f;
    out_ready = r;
    @(posedge clock);
    model_edge(v, d, f, r);
    #1;
    compare(tag);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_sum"}, 32'(out_sum), 32'd0);
    check({tag, ".out_avg"}, 32'(out_avg), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int d;
    checks    = 0;
    errors    = 0;
    holding   = 1'b0;
    exp_sum   = 0;
    exp_avg   = 0;
    exp_peak  = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    #3;
    check_cleared("reset");
    #4;
    reset = 1'b1;

    // Basic window, result visible the cycle after the 4th accept.
    cycle("w1", 1, 10, 0, 1);
    cycle("w1", 1, 20, 0, 1);
    cycle("w1", 1, 30, 0, 1);
    cycle("w1", 1, 40, 0, 1);
    check("w1.sum100", 32'(out_sum), 32'd100);
    check("w1.avg25", 32'(out_avg), 32'd25);
    cycle("w1.drain", 0, 0, 0, 1);

    // Full-scale samples must not overflow.
    for (int i = 0; i < 4; i++) cycle("max", 1, 255, 0, 1);
    check("max.sum1020", 32'(out_sum), 32'd1020);
    check("max.avg255", 32'(out_avg), 32'd255);
    cycle("max.drain", 0, 0, 0, 1);

    // Backpressure: result held, extra samples and flush ignored.
    for (int i = 1; i <= 4; i++) cycle("bp", 1, i, 0, 0);
    for (int i = 0; i < 5; i++) cycle("bp.hold", 1, 99, (i == 2), 0);
    check("bp.sum10", 32'(out_sum), 32'd10);
    cycle("bp.release", 1, 99, 0, 1);
    cycle("bp.next", 1, 5, 0, 1);

    // Flush discards partial window and the sample offered with it.
    cycle("fl", 1, 7, 0, 1);
    cycle("fl", 1, 7, 0, 1);
    cycle("fl.pulse", 1, 200, 1, 1);
    for (int i = 0; i < 4; i++) cycle("fl.win", 1, 1, 0, 1);
    check("fl.sum4", 32'(out_sum), 32'd4);
    check("fl.avg1", 32'(out_avg), 32'd1);
    cycle("fl.drain", 0, 0, 0, 1);

    // Asynchronous reset mid-window, between clock edges.
    cycle("rs", 1, 50, 0, 1);
    cycle("rs", 1, 60, 0, 1);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_cleared("rs.mid");
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle("rs.clean", 1, 8 * (i + 1), 0, 1);
    check("rs.sum80", 32'(out_sum), 32'd80);
    cycle("rs.drain", 0, 0, 0, 1);

    // Asynchronous reset while a result is held.
    for (int i = 0; i < 4; i++) cycle("rh", 1, 100, 0, 0);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_cleared("rh.hold");
    #2;
    reset = 1'b1;

`ifdef PEAK_TRACK_EN
    cycle("pk", 1, 3, 0, 1);
    cycle("pk", 1, 9, 0, 1);
    cycle("pk", 1, 9, 0, 1);
    cycle("pk", 1, 2, 0, 1);
    check("pk.peak9", 32'(out_peak), 32'd9);
    check("pk.sum23", 32'(out_sum), 32'd23);
    check("pk.avg5", 32'(out_avg), 32'd5);
    cycle("pk.drain", 0, 0, 0, 1);
`endif

    // Randomized traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       d = 0;
        1:       d = 255;
        default: d = int'($urandom_range(0, 255));
      endcase
      cycle("rand", ($urandom_range(0, 9) < 7), d,
            ($urandom_range(0, 15) == 0), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
